// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: address width, reset
// vector, sequential step size and the next-PC select encoding.
package pc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef logic [XLEN-1:0] addr_t;

  // Encoding matches the pcjump input bit directly.
  typedef enum logic {
    SEL_PC4 = 1'b0,
    SEL_ALU = 1'b1
  } next_pc_sel_t;

endpackage

// File: rtl/pc_reg.sv
// XLEN-wide program-counter register with synchronous active-high reset
// to RESET_PC. No enable: it loads every non-reset cycle.
module pc_reg #(
  parameter int XLEN = pc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // Reset wins over the incoming next-PC value.
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_PC;
    else     q <= d;
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage of the single-cycle core: holds pc, forms pc+PC_STEP
// and selects between that and the ALU jump/branch target.
// Optional build macro PC_ALIGN_EN: forces jump targets to word alignment by
// clearing aluout[1:0]; the port list is the same either way.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int XLEN = pc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pc_pkg::RESET_PC,
  parameter int PC_STEP = pc_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] aluout,
  input  logic            pcjump,
  output logic [XLEN-1:0] y,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] jump_tgt;
  next_pc_sel_t    sel;

  // Sequential address wraps modulo 2^XLEN; carry-out is dropped on purpose.
  assign pc4 = pc + XLEN'(PC_STEP);

`ifdef PC_ALIGN_EN
  assign jump_tgt = {aluout[XLEN-1:2], 2'b00};
`else
  assign jump_tgt = aluout;
`endif

  assign sel = next_pc_sel_t'(pcjump);

  // Next-PC mux; a jump to the current pc simply holds pc.
  always_comb begin
    y = pc4;
    case (sel)
      SEL_ALU: y = jump_tgt;
      default: y = pc4;
    endcase
  end

  pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk(clk),
    .rst(rst),
    .d  (y),
    .q  (pc)
  );

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vector table followed by
// randomized cycles compared against a simple next-PC model.
module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic [31:0] aluout;
  logic        pcjump;
  logic [31:0] y;
  logic [31:0] pc4;
  logic [31:0] pc;

  int n_checks;
  int n_fail;

  pc_next_unit dut (
    .clk   (clk),
    .rst   (rst),
    .aluout(aluout),
    .pcjump(pcjump),
    .y     (y),
    .pc4   (pc4),
    .pc    (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_ALIGN_EN
  localparam logic [31:0] TGT_107 = 32'h0000_0104;
`else
  localparam logic [31:0] TGT_107 = 32'h0000_0107;
`endif

  typedef struct {
    logic        rst;
    logic        pcjump;
    logic [31:0] aluout;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] a);
`ifdef PC_ALIGN_EN
    return a & ~32'd3;
`else
    return a;
`endif
  endfunction

  // Apply inputs, check outputs at the falling edge, then take the rising edge.
  task automatic apply(input logic r, input logic j, input logic [31:0] a,
                       input logic [31:0] epc, input logic [31:0] epc4,
                       input logic [31:0] ey, input string tag);
    rst    = r;
    pcjump = j;
    aluout = a;
    @(negedge clk);
    check({tag, ".pc"},  pc,  epc);
    check({tag, ".pc4"}, pc4, epc4);
    check({tag, ".y"},   y,   ey);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_y;
    logic        r;
    logic        j;
    logic [31:0] a;

    n_checks = 0;
    n_fail   = 0;

    //             rst   jmp   aluout         pc             pc4            y
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         32'h4};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h8,         32'h8};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'hC,         32'hC};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'h10,        32'h10};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,         32'h10,        32'h14,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,         32'h0,         32'h4,         32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,         32'h0,         32'h4,         32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,         32'h0,         32'h4,         32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         32'h4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h8,         32'h8};
    vecs[10] = '{1'b0, 1'b1, 32'h100,       32'h8,         32'hC,         32'h100};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h100,       32'h104,       32'h104};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h104,       32'h108,       32'hFFFF_FFFC};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         32'h4};
    vecs[15] = '{1'b0, 1'b1, 32'h104,       32'h4,         32'h8,         32'h104};
    vecs[16] = '{1'b1, 1'b1, 32'h200,       32'h104,       32'h108,       32'h200};
    vecs[17] = '{1'b1, 1'b0, 32'h0,         32'h0,         32'h4,         32'h4};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h4,         32'h4};
    vecs[19] = '{1'b0, 1'b1, 32'h107,       32'h4,         32'h8,         TGT_107};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         TGT_107,       TGT_107 + 32'd4, TGT_107 + 32'd4};
    vecs[21] = '{1'b0, 1'b1, 32'h0,         TGT_107 + 32'd4, TGT_107 + 32'd8, 32'h0};

    // Initial reset edge; pc is undefined before it, so nothing is checked yet.
    rst    = 1'b1;
    pcjump = 1'b0;
    aluout = 32'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].rst, vecs[i].pcjump, vecs[i].aluout,
            vecs[i].exp_pc, vecs[i].exp_pc4, vecs[i].exp_y, $sformatf("vec%0d", i));
    end

    // Last vector jumped to 0: pc should now be 0.
    m_pc = 32'h0;

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      j = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFF0 | ($urandom_range(0, 15));
        1:       a = m_pc;
        default: a = $urandom;
      endcase
      m_pc4 = m_pc + 32'd4;
      m_y   = j ? model_target(a) : m_pc4;
      apply(r, j, a, m_pc, m_pc4, m_y, $sformatf("rnd%0d", i));
      m_pc = r ? 32'h0 : m_y;
    end

    // Final state after the random run.
    rst    = 1'b0;
    pcjump = 1'b0;
    @(negedge clk);
    check("final.pc", pc, m_pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
